// File: rtl/spw_tx_pkg.sv
// spw_tx_pkg
//   Shared types and default constants for the transmit-side FCT credit
//   controller.
//   Contents:
//     tx_fct_state_e   credit FSM state encoding (IDLE / ACTIVE / ERR)
//     DEF_CREDIT_W     default credit counter width (bits)
//     DEF_FCT_WEIGHT   default N-Chars granted per received FCT
//     DEF_MAX_CREDIT   default maximum legal outstanding credit
package spw_tx_pkg;

  localparam int DEF_CREDIT_W   = 7;
  localparam int DEF_FCT_WEIGHT = 8;
  localparam int DEF_MAX_CREDIT = 56;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } tx_fct_state_e;

endpackage

// File: rtl/spw_sync_edge.sv
// spw_sync_edge
//   Optional input conditioning (0, 1 or N flops) followed by a single-edge
//   detector. The pulse is one pclk cycle wide and is valid in the cycle
//   before the edge that should act on it.
//   Parameters:
//     SYNC_STAGES  0 = raw input feeds the detector, 1 = single register,
//                  >=2 = multi-flop synchroniser
//     EDGE_RISE    1 = pulse on rising edge, 0 = pulse on falling edge
//   Ports:
//     i_clk    clock
//     i_rst    synchronous active-high reset
//     i_clr    synchronous functional clear (flushes conditioning + history)
//     i_d      input level
//     o_pulse  selected edge pulse
module spw_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_RISE   = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_d,
  output logic o_pulse
);

  logic w_cond;
  logic r_prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign w_cond = i_d;
    end else if (SYNC_STAGES == 1) begin : g_reg
      logic r_q;
      always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_q <= 1'b0;
        else                r_q <= i_d;
      end
      assign w_cond = r_q;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_sync <= '0;
        else                r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      end
      assign w_cond = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // History is cleared to 0 so a level still high after a clear is seen
  // as a fresh rising edge, and a low level is never seen as a falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) r_prev <= 1'b0;
    else                r_prev <= w_cond;
  end

  assign o_pulse = EDGE_RISE ? (w_cond & ~r_prev) : (~w_cond & r_prev);

endmodule

// File: rtl/tx_fct_credit_ctrl.sv
// tx_fct_credit_ctrl
//   Transmit flow-control credit counter. Each received FCT grants
//   FCT_WEIGHT N-Chars; each completed N-Char (falling edge of char_sent)
//   consumes one. Overflow is fatal until reset; underflow is flagged and the
//   credit is held at 0.
//   Build option:
//     TX_FCT_SYNC_EN  defined   -> gotfct_tx passes a 2-flop synchroniser
//                                  (FCT sampled at edge k counts at k+2)
//                     undefined -> single input register (counts at k+1)
//   Ports:
//     pclk_tx           transmit clock
//     reset_tx          synchronous active-high reset
//     enable_tx         link running; low clears credit, history, state
//     gotfct_tx         FCT received (level)
//     char_sent         high while an N-Char is sent
//     fct_counter_p     current credit
//     credit_available  credit is nonzero
//     credit_error      sticky overflow flag
//     underflow_error   sticky consume-at-zero flag
//
//   state  | meaning
//   IDLE   | no credit outstanding, waiting for FCT
//   ACTIVE | credit > 0, N-Chars may be sent
//   ERR    | credit overflow seen; frozen until reset_tx
module tx_fct_credit_ctrl
  import spw_tx_pkg::*;
#(
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int FCT_WEIGHT = DEF_FCT_WEIGHT,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic                pclk_tx,
  input  logic                reset_tx,
  input  logic                enable_tx,
  input  logic                gotfct_tx,
  input  logic                char_sent,
  output logic [CREDIT_W-1:0] fct_counter_p,
  output logic                credit_available,
  output logic                credit_error,
  output logic                underflow_error
);

  localparam int EXT_W = CREDIT_W + 1;
  localparam logic [EXT_W-1:0] WEIGHT_EXT = EXT_W'(FCT_WEIGHT);
  localparam logic [EXT_W-1:0] MAX_EXT    = EXT_W'(MAX_CREDIT);
  localparam logic [EXT_W-1:0] ONE_EXT    = EXT_W'(1);

`ifdef TX_FCT_SYNC_EN
  localparam int FCT_SYNC_STAGES = 2;
`else
  localparam int FCT_SYNC_STAGES = 1;
`endif

  tx_fct_state_e       r_state;
  tx_fct_state_e       w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                r_credit_err;
  logic                w_credit_err_nxt;
  logic                r_uflow_err;
  logic                w_uflow_err_nxt;

  logic                w_clr;
  logic                w_fct_evt;
  logic                w_con_evt;
  logic [EXT_W-1:0]    w_credit_ext;
  logic [EXT_W-1:0]    w_target;

  assign w_clr = ~enable_tx;

  spw_sync_edge #(
    .SYNC_STAGES (FCT_SYNC_STAGES),
    .EDGE_RISE   (1'b1)
  ) u_fct_edge (
    .i_clk   (pclk_tx),
    .i_rst   (reset_tx),
    .i_clr   (w_clr),
    .i_d     (gotfct_tx),
    .o_pulse (w_fct_evt)
  );

  // char_sent is already in the pclk_tx domain, so no conditioning flops.
  spw_sync_edge #(
    .SYNC_STAGES (0),
    .EDGE_RISE   (1'b0)
  ) u_char_edge (
    .i_clk   (pclk_tx),
    .i_rst   (reset_tx),
    .i_clr   (w_clr),
    .i_d     (char_sent),
    .o_pulse (w_con_evt)
  );

  // Candidate credit computed one bit wider so overflow is visible before
  // it could wrap the counter.
  always_comb begin
    w_credit_ext = {1'b0, r_credit};
    w_target     = w_credit_ext;
    if (w_fct_evt && w_con_evt)
      w_target = w_credit_ext + WEIGHT_EXT - ONE_EXT;
    else if (w_fct_evt)
      w_target = w_credit_ext + WEIGHT_EXT;
    else if (w_con_evt)
      w_target = w_credit_ext - ONE_EXT;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_credit_nxt     = r_credit;
    w_credit_err_nxt = r_credit_err;
    w_uflow_err_nxt  = r_uflow_err;

    case (r_state)
      // ERR is only left through reset_tx; a link disable does not thaw it.
      ST_ERR: begin
      end
      default: begin
        if (!enable_tx) begin
          w_credit_nxt = '0;
          w_state_nxt  = ST_IDLE;
        end else if (w_fct_evt && (w_target > MAX_EXT)) begin
          w_credit_err_nxt = 1'b1;
          w_state_nxt      = ST_ERR;
        end else if (w_con_evt && !w_fct_evt && (r_credit == '0)) begin
          w_uflow_err_nxt = 1'b1;
        end else if (w_fct_evt || w_con_evt) begin
          w_credit_nxt = w_target[CREDIT_W-1:0];
          w_state_nxt  = (w_target == '0) ? ST_IDLE : ST_ACTIVE;
        end
      end
    endcase
  end

  always_ff @(posedge pclk_tx) begin
    if (reset_tx) begin
      r_state      <= ST_IDLE;
      r_credit     <= '0;
      r_credit_err <= 1'b0;
      r_uflow_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_credit     <= w_credit_nxt;
      r_credit_err <= w_credit_err_nxt;
      r_uflow_err  <= w_uflow_err_nxt;
    end
  end

  assign fct_counter_p    = r_credit;
  assign credit_available = (r_credit != '0);
  assign credit_error     = r_credit_err;
  assign underflow_error  = r_uflow_err;

endmodule

// File: tb/tb_tx_fct_credit_ctrl.sv
// tb_tx_fct_credit_ctrl
//   Scoreboard bench: a reference model advances once per pclk_tx edge from
//   the sampled inputs and pushes the expected outputs; a negedge monitor pops
//   and compares. Directed scenarios add absolute checks against constants.
module tb_tx_fct_credit_ctrl;

  localparam int CW   = 7;
  localparam int WGT  = 8;
  localparam int MAXC = 56;
`ifdef TX_FCT_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int MAXE = 16384;

  logic          clk = 1'b0;
  logic          reset_tx = 1'b1;
  logic          enable_tx = 1'b1;
  logic          gotfct_tx = 1'b0;
  logic          char_sent = 1'b0;
  logic [CW-1:0] fct_counter_p;
  logic          credit_available;
  logic          credit_error;
  logic          underflow_error;

  int n_checks = 0;
  int n_errors = 0;

  tx_fct_credit_ctrl dut (
    .pclk_tx          (clk),
    .reset_tx         (reset_tx),
    .enable_tx        (enable_tx),
    .gotfct_tx        (gotfct_tx),
    .char_sent        (char_sent),
    .fct_counter_p    (fct_counter_p),
    .credit_available (credit_available),
    .credit_error     (credit_error),
    .underflow_error  (underflow_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit cerr;
    bit uerr;
    bit err;
    int last_clr;
  } mstate_t;

  mstate_t m_st = '{0, 1'b0, 1'b0, 1'b0, -1};
  mstate_t sb_q[$];
  bit      g_hist[MAXE];
  bit      c_hist[MAXE];
  int      n_edge = 0;

  // A sample taken at or before the last clear/reset is treated as 0.
  function automatic bit samp_g(int idx);
    if (idx < 0 || idx >= MAXE || idx <= m_st.last_clr) return 1'b0;
    return g_hist[idx];
  endfunction

  function automatic bit samp_c(int idx);
    if (idx < 0 || idx >= MAXE || idx <= m_st.last_clr) return 1'b0;
    return c_hist[idx];
  endfunction

  // Next model state for the current edge, given this edge's input samples.
  function automatic mstate_t model_next(bit rst, bit en, bit g_now, bit c_now);
    mstate_t s;
    bit fct;
    bit con;
    int delta;
    s = m_st;
    if (rst) begin
      s = '{0, 1'b0, 1'b0, 1'b0, n_edge};
      return s;
    end
    fct = (L == 1) ? (g_now ? 1'b0 : 1'b0) : 1'b0;
    fct = samp_g(n_edge - L) && !samp_g(n_edge - L - 1);
    if (L == 0) fct = g_now;
    con = samp_c(n_edge - 1) && !c_now;
    if (!en) begin
      s.last_clr = n_edge;
      if (!s.err) s.cnt = 0;
    end else if (!s.err) begin
      delta = (fct ? WGT : 0) - (con ? 1 : 0);
      if (fct && (s.cnt + delta > MAXC)) begin
        s.err  = 1'b1;
        s.cerr = 1'b1;
      end else if (con && !fct && s.cnt == 0) begin
        s.uerr = 1'b1;
      end else begin
        s.cnt = s.cnt + delta;
      end
    end
    return s;
  endfunction

  always @(posedge clk) begin
    m_st <= model_next(reset_tx, enable_tx, gotfct_tx, char_sent);
    sb_q.push_back(model_next(reset_tx, enable_tx, gotfct_tx, char_sent));
    if (n_edge < MAXE) begin
      g_hist[n_edge] <= gotfct_tx;
      c_hist[n_edge] <= char_sent;
    end
    n_edge <= n_edge + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_compare(input mstate_t e);
    chk("sb_credit", int'(fct_counter_p), e.cnt);
    chk("sb_avail", int'(credit_available), (e.cnt != 0) ? 1 : 0);
    chk("sb_cerr", int'(credit_error), int'(e.cerr));
    chk("sb_uerr", int'(underflow_error), int'(e.uerr));
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) sb_compare(sb_q.pop_front());
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_tx  = 1'b1;
    enable_tx = 1'b1;
    gotfct_tx = 1'b0;
    char_sent = 1'b0;
    tick(2);
    reset_tx = 1'b0;
    tick(1);
  endtask

  task automatic fct_pulse();
    gotfct_tx = 1'b1;
    tick(1);
    gotfct_tx = 1'b0;
    tick(L + 1);
  endtask

  task automatic consume();
    char_sent = 1'b1;
    tick(1);
    char_sent = 1'b0;
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pg;

    // Reset values, then fill to MAX_CREDIT.
    tick(3);
    reset_tx = 1'b0;
    tick(1);
    chk("rst_credit", int'(fct_counter_p), 0);
    chk("rst_avail", int'(credit_available), 0);
    chk("rst_cerr", int'(credit_error), 0);
    chk("rst_uerr", int'(underflow_error), 0);
    for (int i = 1; i <= 7; i++) begin
      fct_pulse();
      chk("fill_credit", int'(fct_counter_p), 8 * i);
      chk("fill_cerr", int'(credit_error), 0);
    end

    // Overflow: frozen in ERR, consumes ignored.
    fct_pulse();
    chk("ovf_cerr", int'(credit_error), 1);
    chk("ovf_credit", int'(fct_counter_p), 56);
    for (int i = 0; i < 3; i++) consume();
    chk("err_hold_credit", int'(fct_counter_p), 56);
    chk("err_no_uerr", int'(underflow_error), 0);

    // Drain 8 credits then underflow.
    do_reset();
    chk("rst2_cerr", int'(credit_error), 0);
    fct_pulse();
    for (int i = 1; i <= 8; i++) begin
      consume();
      chk("drain_credit", int'(fct_counter_p), 8 - i);
    end
    chk("drain_avail", int'(credit_available), 0);
    chk("drain_uerr", int'(underflow_error), 0);
    consume();
    chk("uflow_uerr", int'(underflow_error), 1);
    chk("uflow_credit", int'(fct_counter_p), 0);

    // Credit 3, simultaneous FCT and consume -> 10.
    do_reset();
    fct_pulse();
    for (int i = 0; i < 5; i++) consume();
    chk("pre_sim_credit", int'(fct_counter_p), 3);
    gotfct_tx = 1'b1;
`ifndef TX_FCT_SYNC_EN
    char_sent = 1'b1;
`endif
    tick(1);
    gotfct_tx = 1'b0;
`ifdef TX_FCT_SYNC_EN
    char_sent = 1'b1;
    tick(1);
`endif
    char_sent = 1'b0;
    tick(1);
    chk("sim_credit", int'(fct_counter_p), 10);
    chk("sim_uerr", int'(underflow_error), 0);

    // Held FCT level counts once; latency depends on conditioning depth.
    do_reset();
    gotfct_tx = 1'b1;
    tick(1);
    chk("hold_k", int'(fct_counter_p), 0);
    tick(1);
    chk("hold_k1", int'(fct_counter_p), (L == 1) ? 8 : 0);
    tick(1);
    chk("hold_k2", int'(fct_counter_p), 8);
    tick(17);
    gotfct_tx = 1'b0;
    tick(4);
    chk("hold_once", int'(fct_counter_p), 8);

    // Enable low clears credit, keeps flags; reset clears flags.
    do_reset();
    consume();
    chk("en_pre_uerr", int'(underflow_error), 1);
    for (int i = 0; i < 5; i++) fct_pulse();
    chk("en_pre_credit", int'(fct_counter_p), 40);
    enable_tx = 1'b0;
    tick(1);
    enable_tx = 1'b1;
    chk("en_clr_credit", int'(fct_counter_p), 0);
    chk("en_clr_avail", int'(credit_available), 0);
    chk("en_keep_uerr", int'(underflow_error), 1);
    reset_tx = 1'b1;
    tick(1);
    reset_tx = 1'b0;
    tick(1);
    chk("rst_flags_uerr", int'(underflow_error), 0);

    // Randomised segments, each with its own FCT density.
    for (int seg = 0; seg < 10; seg++) begin
      do_reset();
      pg = $urandom_range(6, 40);
      for (int i = 0; i < 300; i++) begin
        reset_tx  = ($urandom_range(0, 499) == 0);
        enable_tx = ($urandom_range(0, 63) != 0);
        gotfct_tx = ($urandom_range(0, pg - 1) == 0);
        char_sent = $urandom_range(0, 1);
        tick(1);
      end
    end
    reset_tx  = 1'b0;
    gotfct_tx = 1'b0;
    char_sent = 1'b0;
    tick(2);

    @(negedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
